condition_predicate_sequencer: RTL and testbench

- Per-thread scheduler for the branch condition-predicate unit in the multithreaded pipeline.
- Holds each thread's predicate configuration (A group selector, B group selector, dyadic operator) and a per-thread reloadable loop counter.
- Steps round-robin through threads, one per cycle, and presents that thread's configuration and counter flag to the predicate unit.
- The counter flag drives the predicate unit's B_counter input. Configuration and counters are written through a memory-mapped write port.

---
 rtl/condition_predicate_sequencer.sv | 113 +++++++++++
 tb/tb_condition_predicate_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/condition_predicate_sequencer.sv
// Round-robin per-thread scheduler for the branch condition-predicate unit.
// Presents one thread's predicate config and counter-zero flag per enabled cycle.
module condition_predicate_sequencer #(
   parameter int unsigned THREAD_COUNT         = 8,
   parameter int unsigned THREAD_ADDR_WIDTH    = 3,
   parameter int unsigned GROUP_SELECTOR_WIDTH = 2,
   parameter int unsigned DYADIC_CTRL_WIDTH    = 4,
   parameter int unsigned COUNTER_WIDTH        = 16
) (
   input  logic                                                   clock,
   input  logic                                                   reset,
   input  logic                                                   enable,
   input  logic                                                   config_wren,
   input  logic [THREAD_ADDR_WIDTH-1:0]                           config_thread,
   input  logic [2*GROUP_SELECTOR_WIDTH+DYADIC_CTRL_WIDTH-1:0]    config_data,
   input  logic                                                   counter_wren,
   input  logic [THREAD_ADDR_WIDTH-1:0]                           counter_thread,
   input  logic [COUNTER_WIDTH-1:0]                               counter_data,
   input  logic                                                   counter_decrement,
   output logic                                                   out_valid,
   output logic [THREAD_ADDR_WIDTH-1:0]                           out_thread,
   output logic [GROUP_SELECTOR_WIDTH-1:0]                        A_selector,
   output logic [GROUP_SELECTOR_WIDTH-1:0]                        B_selector,
   output logic [DYADIC_CTRL_WIDTH-1:0]                           AB_operator,
   output logic                                                   B_counter
);

   localparam int unsigned CFG_WIDTH = 2*GROUP_SELECTOR_WIDTH + DYADIC_CTRL_WIDTH;
   localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD  = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
   localparam logic [THREAD_ADDR_WIDTH:0]   THREAD_LIMIT = (THREAD_ADDR_WIDTH + 1)'(THREAD_COUNT);

   logic [THREAD_ADDR_WIDTH-1:0] cur_q, cur_d;
   logic                         out_valid_q, out_valid_d;
   logic [THREAD_ADDR_WIDTH-1:0] out_thread_q, out_thread_d;
   logic [CFG_WIDTH-1:0]         out_cfg_q, out_cfg_d;
   logic                         b_counter_q, b_counter_d;

   logic [CFG_WIDTH-1:0]     cfg_q    [THREAD_COUNT];
   logic [CFG_WIDTH-1:0]     cfg_d    [THREAD_COUNT];
   logic [COUNTER_WIDTH-1:0] count_q  [THREAD_COUNT];
   logic [COUNTER_WIDTH-1:0] count_d  [THREAD_COUNT];
   logic [COUNTER_WIDTH-1:0] reload_q [THREAD_COUNT];
   logic [COUNTER_WIDTH-1:0] reload_d [THREAD_COUNT];

   logic config_hit;
   logic counter_hit;

   assign config_hit  = config_wren  && ({1'b0, config_thread}  < THREAD_LIMIT);
   assign counter_hit = counter_wren && ({1'b0, counter_thread} < THREAD_LIMIT);

   always_comb begin
      cur_d        = cur_q;
      out_valid_d  = out_valid_q;
      out_thread_d = out_thread_q;
      out_cfg_d    = out_cfg_q;
      b_counter_d  = b_counter_q;
      cfg_d        = cfg_q;
      count_d      = count_q;
      reload_d     = reload_q;

      if (enable) begin
         cur_d        = (cur_q == LAST_THREAD) ? '0 : cur_q + THREAD_ADDR_WIDTH'(1);
         out_valid_d  = 1'b1;
         out_thread_d = cur_q;
         out_cfg_d    = cfg_q[cur_q];
         b_counter_d  = (count_q[cur_q] == '0);
         // The step targets the slot already on the outputs, never the one being registered.
         if (counter_decrement) begin
            if (count_q[out_thread_q] == '0)
               count_d[out_thread_q] = reload_q[out_thread_q];
            else
               count_d[out_thread_q] = count_q[out_thread_q] - COUNTER_WIDTH'(1);
         end
      end

      if (counter_hit) begin
         count_d[counter_thread]  = counter_data;
         reload_d[counter_thread] = counter_data;
      end
      if (config_hit)
         cfg_d[config_thread] = config_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_q        <= '0;
         out_valid_q  <= 1'b0;
         out_thread_q <= '0;
         out_cfg_q    <= '0;
         b_counter_q  <= 1'b0;
         cfg_q        <= '{default: '0};
         count_q      <= '{default: '0};
         reload_q     <= '{default: '0};
      end else begin
         cur_q        <= cur_d;
         out_valid_q  <= out_valid_d;
         out_thread_q <= out_thread_d;
         out_cfg_q    <= out_cfg_d;
         b_counter_q  <= b_counter_d;
         cfg_q        <= cfg_d;
         count_q      <= count_d;
         reload_q     <= reload_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_thread  = out_thread_q;
   assign A_selector  = out_cfg_q[CFG_WIDTH-1 -: GROUP_SELECTOR_WIDTH];
   assign B_selector  = out_cfg_q[DYADIC_CTRL_WIDTH +: GROUP_SELECTOR_WIDTH];
   assign AB_operator = out_cfg_q[DYADIC_CTRL_WIDTH-1:0];
   assign B_counter   = b_counter_q;

endmodule

// File: tb/tb_condition_predicate_sequencer.sv
// Directed plus randomized bench for condition_predicate_sequencer with a per-thread reference model.
module tb_condition_predicate_sequencer;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int GW = 2;
   localparam int OW = 4;
   localparam int CW = 16;
   localparam int DW = 2*GW + OW;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic          config_wren;
   logic [AW-1:0] config_thread;
   logic [DW-1:0] config_data;
   logic          counter_wren;
   logic [AW-1:0] counter_thread;
   logic [CW-1:0] counter_data;
   logic          counter_decrement;
   logic          out_valid;
   logic [AW-1:0] out_thread;
   logic [GW-1:0] A_selector;
   logic [GW-1:0] B_selector;
   logic [OW-1:0] AB_operator;
   logic          B_counter;

   condition_predicate_sequencer #(
      .THREAD_COUNT(N), .THREAD_ADDR_WIDTH(AW), .GROUP_SELECTOR_WIDTH(GW),
      .DYADIC_CTRL_WIDTH(OW), .COUNTER_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .config_wren(config_wren), .config_thread(config_thread), .config_data(config_data),
      .counter_wren(counter_wren), .counter_thread(counter_thread), .counter_data(counter_data),
      .counter_decrement(counter_decrement),
      .out_valid(out_valid), .out_thread(out_thread), .A_selector(A_selector),
      .B_selector(B_selector), .AB_operator(AB_operator), .B_counter(B_counter)
   );

   always #5 clock = ~clock;

   // Reference model: plain integer state per thread.
   int      m_cur;
   int      m_cfg [N];
   int      m_cnt [N];
   int      m_rld [N];
   int      m_valid, m_thread, m_cfg_out, m_bc;
   int      nchk = 0;
   int      nerr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("out_valid",   32'(out_valid),   32'(m_valid));
      check("out_thread",  32'(out_thread),  32'(m_thread));
      check("A_selector",  32'(A_selector),  32'(m_cfg_out / 64));
      check("B_selector",  32'(B_selector),  32'((m_cfg_out / 16) % 4));
      check("AB_operator", 32'(AB_operator), 32'(m_cfg_out % 16));
      check("B_counter",   32'(B_counter),   32'(m_bc));
   endtask

   task automatic model_reset();
      m_cur = 0; m_valid = 0; m_thread = 0; m_cfg_out = 0; m_bc = 0;
      for (int i = 0; i < N; i++) begin
         m_cfg[i] = 0; m_cnt[i] = 0; m_rld[i] = 0;
      end
   endtask

   task automatic idle_inputs();
      config_wren = 0; config_thread = '0; config_data = '0;
      counter_wren = 0; counter_thread = '0; counter_data = '0;
      counter_decrement = 0;
   endtask

   // Advance one clock: predict from the current inputs, then compare after the edge.
   task automatic tick();
      int prev = m_thread;
      if (enable) begin
         m_thread  = m_cur;
         m_cfg_out = m_cfg[m_cur];
         m_bc      = (m_cnt[m_cur] == 0);
         m_valid   = 1;
         m_cur     = (m_cur + 1) % N;
         if (counter_decrement)
            m_cnt[prev] = (m_cnt[prev] == 0) ? m_rld[prev] : m_cnt[prev] - 1;
      end
      if (counter_wren && counter_thread < N) begin
         m_cnt[counter_thread] = counter_data;
         m_rld[counter_thread] = counter_data;
      end
      if (config_wren && config_thread < N)
         m_cfg[config_thread] = config_data;
      @(posedge clock);
      #1;
      check_all();
   endtask

   int exp_seq [6] = '{0, 0, 1, 0, 0, 1};

   initial begin
      int slots, guard;
      logic [DW-1:0] cfg_val;

      // Reset state
      reset = 1; enable = 0; idle_inputs();
      model_reset();
      #12;
      check_all();
      reset = 0;

      // Plain rotation after reset
      enable = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("seq_thread", 32'(out_thread), 32'(i % N));
      end

      // Config write to thread 3 on the edge that registers thread 3: no bypass
      tick();                                   // cur now 3
      config_wren = 1; config_thread = 3; config_data = 8'b10_01_1000;
      tick();
      config_wren = 0;
      check("cfg_nobypass_thr", 32'(out_thread), 32'd3);
      check("cfg_nobypass_A",   32'(A_selector), 32'd0);
      for (int i = 0; i < N; i++) tick();
      check("cfg_next_thr", 32'(out_thread),  32'd3);
      check("cfg_next_A",   32'(A_selector),  32'd2);
      check("cfg_next_B",   32'(B_selector),  32'd1);
      check("cfg_next_op",  32'(AB_operator), 32'd8);

      // Reload-2 counter on thread 5 with a decrement after every thread-5 slot
      counter_wren = 1; counter_thread = 5; counter_data = 16'd2;
      tick();
      counter_wren = 0;
      slots = 0; guard = 0;
      while (slots < 6 && guard < 80) begin
         counter_decrement = (out_valid && out_thread == 5);
         tick();
         guard++;
         if (out_thread == 5) begin
            check("thr5_flag_seq", 32'(B_counter), 32'(exp_seq[slots]));
            slots++;
         end
      end
      check("thr5_seq_slots", 32'(slots), 32'd6);

      // Counter write beats a same-cycle decrement on the same thread
      counter_decrement = 1; counter_wren = 1; counter_thread = 5; counter_data = 16'd7;
      tick();
      counter_wren = 0;
      slots = 0; guard = 0;
      while (slots < 8 && guard < 100) begin
         counter_decrement = (out_valid && out_thread == 5);
         tick();
         guard++;
         if (out_thread == 5) begin
            check("thr5_after_wr7", 32'(B_counter), (slots == 7) ? 32'd1 : 32'd0);
            slots++;
         end
      end
      check("thr5_wr7_slots", 32'(slots), 32'd8);
      counter_decrement = 0;

      // Enable low holds everything even with decrement asserted
      guard = 0;
      while (out_thread != 4 && guard < 20) begin
         tick();
         guard++;
      end
      check("hold_start_thr", 32'(out_thread), 32'd4);
      enable = 0; counter_decrement = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_thr", 32'(out_thread), 32'd4);
      end
      enable = 1; counter_decrement = 0;
      tick();
      check("resume_thr", 32'(out_thread), 32'd5);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         enable            = ($urandom_range(0, 9) < 8);
         config_wren       = ($urandom_range(0, 3) == 0);
         config_thread     = AW'($urandom_range(0, N-1));
         cfg_val           = DW'($urandom);
         config_data       = cfg_val;
         counter_wren      = ($urandom_range(0, 7) == 0);
         counter_thread    = AW'($urandom_range(0, N-1));
         counter_data      = CW'($urandom_range(0, 3));
         counter_decrement = ($urandom_range(0, 1) == 1);
         tick();
      end
      idle_inputs();
      enable = 1;
      config_wren = 1; config_thread = 6; config_data = 8'hFF;
      tick();
      config_wren = 0;

      // Asynchronous reset mid-cycle
      #2;
      reset = 1;
      #1;
      model_reset();
      check_all();
      @(posedge clock);
      #1;
      check_all();
      reset = 0;
      for (int i = 0; i < N; i++) begin
         tick();
         check("post_rst_thr", 32'(out_thread), 32'(i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
